// File: rtl/ssd_scan_decoder.sv
// Passive monitor that recovers hex digits from a multiplexed seven-segment bus.
// Define SSD_DEC_TIMEOUT_EN to enable the idle-bus timeout and the stale flag.
module ssd_scan_decoder #(
    parameter int NUM_DIGITS     = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STABLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              g_to_a,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_err,
    output logic                    valid,
    output logic                    stale
);

    localparam int N  = NUM_DIGITS;
    localparam int SW = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int FW = $clog2(STABLE_FRAMES + 1);

    localparam logic [N-1:0]  ONE      = N'(1);
    localparam logic [CW-1:0] SET_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [FW-1:0] STAB_MAX = FW'(STABLE_FRAMES);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } state_t;

    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'b1000000: decode = 5'h00;
            7'b1111001: decode = 5'h01;
            7'b0100100: decode = 5'h02;
            7'b0110000: decode = 5'h03;
            7'b0011001: decode = 5'h04;
            7'b0010010: decode = 5'h05;
            7'b0000010: decode = 5'h06;
            7'b1111000: decode = 5'h07;
            7'b0000000: decode = 5'h08;
            7'b0010000: decode = 5'h09;
            7'b0001000: decode = 5'h0a;
            7'b0000011: decode = 5'h0b;
            7'b1000110: decode = 5'h0c;
            7'b0100001: decode = 5'h0d;
            7'b0000110: decode = 5'h0e;
            7'b0001110: decode = 5'h0f;
            default:    decode = 5'h10;
        endcase
    endfunction

    logic [N-1:0]    an_s1, an_s2;
    logic [6:0]      seg_s1, seg_s2, seg_q;
    logic [N-1:0]    low;
    logic            sel_ok;
    logic [SW-1:0]   sel_idx;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   cur;
    logic            cap;
    logic [N-1:0]    cap_bit;
    logic [4:0]      dec_w;
    logic [4*N-1:0]  buf_nib, prev_nib;
    logic [N-1:0]    buf_err, prev_err, mask;
    logic [FW-1:0]   stab, stab_nx;
    logic            complete, frame_eq, pub_now, pend;
    logic            to_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_s1  <= '1;
            an_s2  <= '1;
            seg_s1 <= '1;
            seg_s2 <= '1;
            seg_q  <= '1;
        end else begin
            an_s1  <= an;
            an_s2  <= an_s1;
            seg_s1 <= g_to_a;
            seg_s2 <= seg_s1;
            seg_q  <= seg_s2;
        end
    end

    always_comb begin
        low     = ~an_s2;
        sel_ok  = (low != '0) && ((low & (low - ONE)) == '0);
        sel_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (low[i]) sel_idx = SW'(i);
        end
    end

    // seg_q lags by one cycle so the captured pattern belongs to the
    // select the counter was qualified against, even if it just changed.
    assign cap     = (state == SETTLE) && (cnt == SET_MAX);
    assign cap_bit = cap ? (ONE << cur) : '0;
    assign dec_w   = decode(seg_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            cur   <= '0;
        end else if (!sel_ok) begin
            state <= IDLE;
        end else if (state == IDLE || sel_idx != cur) begin
            state <= SETTLE;
            cnt   <= CW'(1);
            cur   <= sel_idx;
        end else if (state == SETTLE) begin
            if (cap) state <= HOLD;
            else     cnt   <= cnt + CW'(1);
        end
    end

    always_comb begin
        complete = &mask;
        frame_eq = (buf_nib == prev_nib) && (buf_err == prev_err);
        if (frame_eq) stab_nx = (stab == STAB_MAX) ? stab : stab + FW'(1);
        else          stab_nx = FW'(1);
        pub_now = complete && (stab_nx == STAB_MAX)
                  && !(frame_eq && stab == STAB_MAX);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_nib  <= '0;
            buf_err  <= '0;
            prev_nib <= '0;
            prev_err <= '0;
            mask     <= '0;
            stab     <= '0;
            pend     <= 1'b0;
        end else begin
            if (cap) begin
                buf_nib[4*cur +: 4] <= dec_w[3:0];
                buf_err[cur]        <= dec_w[4];
            end
            if (complete) begin
                prev_nib <= buf_nib;
                prev_err <= buf_err;
                stab     <= stab_nx;
            end
            mask <= (complete ? '0 : mask) | cap_bit;
            pend <= pub_now;
            if (to_hit) begin
                mask <= '0;
                stab <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value     <= '0;
            digit_err <= '0;
            valid     <= 1'b0;
        end else begin
            valid <= pend;
            if (pend) begin
                value     <= prev_nib;
                digit_err <= prev_err;
            end
        end
    end

`ifdef SSD_DEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] idle_cnt;

    assign to_hit = (idle_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= '0;
        end else if (sel_ok) begin
            idle_cnt <= '0;
        end else if (state == IDLE && !to_hit) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale <= 1'b0;
        end else if (to_hit) begin
            stale <= 1'b1;
        end else if (pend) begin
            stale <= 1'b0;
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign to_hit         = 1'b0;
    assign stale          = 1'b0;
`endif

endmodule

// File: tb/tb_ssd_scan_decoder.sv
// Bench for ssd_scan_decoder: directed steps plus randomized scans against
// a frame-level reference model of the display bus.
module tb_ssd_scan_decoder;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int SF = 2;
    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  an = 4'hF;
    logic [6:0]  g_to_a = 7'h7F;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        valid;
    logic        stale;

    ssd_scan_decoder #(
        .NUM_DIGITS(N),
        .SETTLE_CYCLES(S),
        .STABLE_FRAMES(SF),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .an(an),
        .g_to_a(g_to_a),
        .value(value),
        .digit_err(digit_err),
        .valid(valid),
        .stale(stale)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [6:0] pats [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [3:0]  m_nib [4];
    logic        m_err [4];
    logic [3:0]  m_mask;
    logic [19:0] m_prev;
    int          m_cnt;
    logic [19:0] expq [$];
    logic [19:0] obsq [$];

    always @(negedge clk) begin
        if (valid === 1'b1) obsq.push_back({digit_err, value});
    end

    function automatic logic [4:0] ref_dec(input logic [6:0] p);
        for (int k = 0; k < 16; k++) begin
            if (pats[k] == p) return {1'b0, 4'(k)};
        end
        return 5'h10;
    endfunction

    function automatic logic [27:0] fr(input logic [15:0] v);
        logic [27:0] r;
        for (int d = 0; d < N; d++) r[7*d +: 7] = pats[v[4*d +: 4]];
        return r;
    endfunction

    task automatic model_reset();
        m_mask = '0;
        m_prev = '0;
        m_cnt  = 0;
        for (int d = 0; d < N; d++) begin
            m_nib[d] = '0;
            m_err[d] = 1'b0;
        end
    endtask

    task automatic model_capture(input int d, input logic [6:0] p);
        logic [4:0]  r;
        logic [19:0] f;
        logic        eq;
        int          nc;
        r = ref_dec(p);
        m_nib[d] = r[3:0];
        m_err[d] = r[4];
        m_mask[d] = 1'b1;
        if (m_mask == 4'hF) begin
            for (int k = 0; k < N; k++) begin
                f[4*k +: 4] = m_nib[k];
                f[16+k]     = m_err[k];
            end
            eq = (f == m_prev);
            nc = eq ? ((m_cnt < SF) ? m_cnt + 1 : SF) : 1;
            if (nc == SF && !(eq && m_cnt == SF)) expq.push_back(f);
            m_cnt  = nc;
            m_prev = f;
            m_mask = '0;
        end
    endtask

    task automatic dwell(input logic [3:0] a, input logic [6:0] p, input int len);
        @(negedge clk);
        an = a;
        g_to_a = p;
        repeat (len) @(posedge clk);
        if ($countones(~a) == 1 && len >= S) begin
            for (int d = 0; d < N; d++) begin
                if (!a[d]) model_capture(d, p);
            end
        end
    endtask

    task automatic digit(input int d, input logic [6:0] p, input int len);
        logic [3:0] a;
        a = 4'hF;
        a[d] = 1'b0;
        dwell(a, p, len);
    endtask

    task automatic scan(input logic [27:0] ps);
        for (int d = 0; d < N; d++) digit(d, ps[7*d +: 7], 8);
    endtask

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic check_pubs(input string tag);
        int n;
        dwell(4'hF, 7'h7F, 16);
        chk({tag, " pulses"}, obsq.size(), expq.size());
        n = (obsq.size() < expq.size()) ? obsq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, " frame"}, 32'(obsq[i]), 32'(expq[i]));
        end
    endtask

    logic [27:0] ps;
    logic [3:0]  gap;
    int          reps;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst value", 32'(value), 0);
        chk("rst err", 32'(digit_err), 0);
        chk("rst valid", 32'(valid), 0);
        chk("rst stale", 32'(stale), 0);
        rst_n = 1'b1;

        scan(fr(16'h1234));
        scan(fr(16'h1234));
        check_pubs("two frames");
        chk("1234 count", obsq.size(), 1);
        chk("1234 value", 32'(value), 32'h1234);
        chk("1234 err", 32'(digit_err), 0);
        scan(fr(16'h1234));
        check_pubs("third frame");
        chk("no repub", obsq.size(), 1);

        scan(fr(16'h1F34));
        check_pubs("changed once");
        chk("changed once count", obsq.size(), 1);
        scan(fr(16'h1F34));
        check_pubs("changed twice");
        chk("changed count", obsq.size(), 2);
        chk("changed value", 32'(value), 32'h1F34);

        ps = fr(16'h1F34);
        ps[13:7] = 7'h7F;
        scan(ps);
        scan(ps);
        check_pubs("blank");
        chk("blank count", obsq.size(), 3);
        chk("blank value", 32'(value), 32'h1F04);
        chk("blank err", 32'(digit_err), 32'h2);

        ps = fr(16'h8765);
        scan(ps);
        for (int d = 0; d < 3; d++) digit(d, ps[7*d +: 7], 8);
        digit(3, ps[27:21], 3);
        dwell(4'h0, 7'h00, 4);
        check_pubs("short dwell");
        chk("short count", obsq.size(), 3);
        digit(3, ps[27:21], 8);
        check_pubs("completed");
        chk("completed count", obsq.size(), 4);
        chk("completed value", 32'(value), 32'h8765);

        ps = fr(16'hCBA9);
        digit(0, ps[6:0], 8);
        digit(1, ps[13:7], 8);
        @(negedge clk);
        rst_n = 1'b0;
        an = 4'hF;
        #1;
        chk("mid rst value", 32'(value), 0);
        chk("mid rst err", 32'(digit_err), 0);
        chk("mid rst valid", 32'(valid), 0);
        chk("mid rst stale", 32'(stale), 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        digit(2, ps[20:14], 8);
        digit(3, ps[27:21], 8);
        scan(ps);
        check_pubs("after reset");
        chk("after rst count", obsq.size(), 4);
        chk("after rst value", 32'(value), 0);
        scan(ps);
        check_pubs("reset publish");
        chk("rst pub value", 32'(value), 32'hCBA9);

`ifdef SSD_DEC_TIMEOUT_EN
        dwell(4'hF, 7'h7F, 50);
        chk("pre timeout", 32'(stale), 0);
        dwell(4'hF, 7'h7F, 70);
        chk("timeout stale", 32'(stale), 1);
        chk("timeout value", 32'(value), 32'hCBA9);
        m_mask = '0;
        m_cnt  = 0;
        scan(ps);
        scan(ps);
        check_pubs("post timeout");
        chk("post to count", obsq.size(), 6);
        chk("stale cleared", 32'(stale), 0);
`else
        dwell(4'hF, 7'h7F, 120);
        chk("idle stale", 32'(stale), 0);
        chk("idle value", 32'(value), 32'hCBA9);
`endif

        for (int f = 0; f < 12; f++) begin
            for (int d = 0; d < N; d++) begin
                if ($urandom_range(7, 0) == 0) ps[7*d +: 7] = 7'($urandom);
                else ps[7*d +: 7] = pats[$urandom_range(15, 0)];
            end
            reps = int'($urandom_range(3, 1));
            for (int r = 0; r < reps; r++) begin
                for (int d = 0; d < N; d++) begin
                    if ($urandom_range(7, 0) == 0) begin
                        case ($urandom_range(2, 0))
                            0:       gap = 4'hF;
                            1:       gap = 4'h0;
                            default: gap = 4'b0101;
                        endcase
                        dwell(gap, 7'($urandom), int'($urandom_range(3, 1)));
                    end
                    digit(d, ps[7*d +: 7], int'($urandom_range(S + 5, S - 1)));
                end
            end
        end
        check_pubs("random");
        chk("final stale", 32'(stale), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
